icache_tag_sram: RTL and testbench

Single-port synchronous tag memory for the instruction cache: 128 entries × 21 bits (bit 20 = valid, bits 19:0 = physical tag PA[31:12]), indexed by the cache set index PA[11:5]. It sits beside the I-cache data RAMs; the cache controller reads the tag for hit comparison one cycle after presenting the index, and writes it on refill or invalidate. Byte-lane write enables keep it interface-compatible with the vendor block-RAM macro it replaces.

---
 rtl/icache_pkg.sv | 30 +++
 rtl/tag_clear_seq.sv | 64 ++++++
 rtl/icache_tag_sram.sv | 111 +++++++++++
 tb/tb_icache_tag_sram.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// -----------------------------------------------------------------------------
// icache_pkg
// Shared definitions for the instruction-cache tag store.
//   ICACHE_INDEX_W     set index width (PA[11:5])
//   ICACHE_TAG_W       physical tag width (PA[31:12])
//   ICACHE_TAG_ENTRY_W stored entry width (valid + tag)
//   ICACHE_VALID_BIT   position of the valid bit inside an entry
//   ICACHE_WE_W        byte-lane write-enable width of the RAM port
// -----------------------------------------------------------------------------
package icache_pkg;

    localparam int unsigned ICACHE_INDEX_W     = 7;
    localparam int unsigned ICACHE_TAG_W       = 20;
    localparam int unsigned ICACHE_TAG_ENTRY_W = 21;
    localparam int unsigned ICACHE_VALID_BIT   = 20;
    localparam int unsigned ICACHE_WE_W        = 4;

    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
    } icache_tag_entry_t;

    // Power-up clear sequencer states.
    typedef enum logic [1:0] {
        CLR_SYNC,
        CLR_SWEEP,
        CLR_DONE
    } clr_state_t;

endpackage

// File: rtl/tag_clear_seq.sv
// -----------------------------------------------------------------------------
// tag_clear_seq
// After reset release, walks every tag index once, requesting a zero write per
// cycle, then raises ready. The first edge after release only leaves CLR_SYNC,
// which aligns reset deassertion to clk before the sweep starts.
// Ports:
//   clk      clock
//   rst_n    asynchronous active-low reset (restarts the sweep at index 0)
//   ready    high once the sweep has completed
//   clr_we   clear write request for the current cycle
//   clr_addr index being cleared
// -----------------------------------------------------------------------------
module tag_clear_seq
    import icache_pkg::*;
#(
    parameter int unsigned ADDR_W = ICACHE_INDEX_W
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              ready,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    clr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLR_SYNC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clr_we   = 1'b0;
        clr_addr = cnt_q;
        ready    = 1'b0;
        case (state_q)
            CLR_SYNC: begin
                state_d = CLR_SWEEP;
            end
            CLR_SWEEP: begin
                clr_we = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = CLR_DONE;
                end
            end
            CLR_DONE: begin
                ready = 1'b1;
            end
            default: begin
                state_d = CLR_SYNC;
            end
        endcase
    end

endmodule

// File: rtl/icache_tag_sram.sv
// -----------------------------------------------------------------------------
// icache_tag_sram
// Single-port synchronous I-cache tag memory (valid + PA tag per set) with
// byte-lane write enables and write-first registered read data.
// Optional feature macro: ICACHE_TAG_CLEAR_EN -- zero every entry after reset
// release before accepting accesses.
// Ports:
//   clka    clock
//   rsta_n  asynchronous active-low reset (clears douta and ready only)
//   ena     port enable
//   wea     byte-lane write enables (lane k = bits 8k+7:8k, clipped)
//   addra   entry index
//   dina    write data
//   douta   registered read / write-first data
//   ready   high when accesses are accepted
// -----------------------------------------------------------------------------
module icache_tag_sram
    import icache_pkg::*;
#(
    parameter int unsigned ADDR_W = ICACHE_INDEX_W,
    parameter int unsigned DATA_W = ICACHE_TAG_ENTRY_W,
    parameter int unsigned WE_W   = ICACHE_WE_W
) (
    input  logic              clka,
    input  logic              rsta_n,
    input  logic              ena,
    input  logic [WE_W-1:0]   wea,
    input  logic [ADDR_W-1:0] addra,
    input  logic [DATA_W-1:0] dina,
    output logic [DATA_W-1:0] douta,
    output logic              ready
);

    // No reset on the array so it maps onto block RAM.
    logic [DATA_W-1:0] mem [2**ADDR_W] = '{default: '0};

    logic [DATA_W-1:0] lane_mask;
    logic [DATA_W-1:0] merged;
    logic              access;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    // Lanes that fall beyond DATA_W have no bits and are ignored.
    for (genvar i = 0; i < DATA_W; i++) begin : g_mask
        if ((i / 8) < WE_W) begin : g_lane
            assign lane_mask[i] = wea[i/8];
        end else begin : g_none
            assign lane_mask[i] = 1'b0;
        end
    end

    assign access = ready & ena;
    assign merged = (mem[addra] & ~lane_mask) | (dina & lane_mask);

`ifdef ICACHE_TAG_CLEAR_EN
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    tag_clear_seq #(
        .ADDR_W(ADDR_W)
    ) u_clear (
        .clk     (clka),
        .rst_n   (rsta_n),
        .ready   (ready),
        .clr_we  (clr_we),
        .clr_addr(clr_addr)
    );

    always_comb begin
        wr_en   = access & (|wea);
        wr_addr = addra;
        wr_data = merged;
        if (clr_we) begin
            wr_en   = 1'b1;
            wr_addr = clr_addr;
            wr_data = '0;
        end
    end
`else
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            ready <= 1'b0;
        end else begin
            ready <= 1'b1;
        end
    end

    always_comb begin
        wr_en   = access & (|wea);
        wr_addr = addra;
        wr_data = merged;
    end
`endif

    always_ff @(posedge clka) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Write-first: a write returns the merged post-write word.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            douta <= '0;
        end else if (access) begin
            douta <= (|wea) ? merged : mem[addra];
        end
    end

endmodule

// File: tb/tb_icache_tag_sram.sv
module tb_icache_tag_sram;

    logic        clka = 1'b0;
    logic        rsta_n;
    logic        ena;
    logic [3:0]  wea;
    logic [6:0]  addra;
    logic [20:0] dina;
    logic [20:0] douta;
    logic        ready;

    int checks = 0;
    int errors = 0;

    logic [20:0] model_mem [128];
    logic [20:0] exp_last;
    logic [20:0] exp_q [$];

    icache_tag_sram #(
        .ADDR_W(7),
        .DATA_W(21),
        .WE_W  (4)
    ) dut (
        .clka  (clka),
        .rsta_n(rsta_n),
        .ena   (ena),
        .wea   (wea),
        .addra (addra),
        .dina  (dina),
        .douta (douta),
        .ready (ready)
    );

    always #5 clka = ~clka;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [20:0] lane_merge(input logic [20:0] old,
                                               input logic [20:0] din,
                                               input logic [3:0]  we);
        logic [20:0] m;
        m = old;
        if (we[0]) m[7:0]   = din[7:0];
        if (we[1]) m[15:8]  = din[15:8];
        if (we[2]) m[20:16] = din[20:16];
        return m;
    endfunction

    // Drive one cycle of stimulus, push the expected douta, advance past the edge.
    task automatic step(input logic en, input logic [3:0] we,
                        input logic [6:0] addr, input logic [20:0] din);
        ena   = en;
        wea   = we;
        addra = addr;
        dina  = din;
        if (en) begin
            if (we != 4'h0) begin
                model_mem[addr] = lane_merge(model_mem[addr], din, we);
                exp_last = model_mem[addr];
            end else begin
                exp_last = model_mem[addr];
            end
        end
        exp_q.push_back(exp_last);
        @(posedge clka);
        #1;
        ena = 1'b0;
        wea = 4'h0;
    endtask

    task automatic test_reset;
        int n;
        int exp_n;
        rsta_n = 1'b0;
        ena    = 1'b0;
        wea    = 4'h0;
        addra  = '0;
        dina   = '0;
        repeat (3) @(posedge clka);
        #1;
        checks++;
        if (douta !== 21'h0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: douta=%h ready=%b required douta=0 ready=0", douta, ready);
        end
        rsta_n = 1'b1;
`ifdef ICACHE_TAG_CLEAR_EN
        exp_n = 129;
`else
        exp_n = 1;
`endif
        n = 0;
        while (ready !== 1'b1 && n < 300) begin
            @(posedge clka);
            #1;
            n++;
        end
        checks++;
        if (n != exp_n) begin
            errors++;
            $display("FAIL ready_latency: edges=%0d required %0d", n, exp_n);
        end
        exp_last = 21'h0;
`ifdef ICACHE_TAG_CLEAR_EN
        for (int i = 0; i < 128; i++) model_mem[i] = 21'h0;
`endif
    endtask

    task automatic test_basic;
        logic [20:0] e;
        step(1'b1, 4'hF, 7'd5, 21'h1ABCDE);
        e = exp_q.pop_front();
        checks++;
        if (douta !== e) begin
            errors++;
            $display("FAIL basic_write: douta=%h required %h", douta, e);
        end
        step(1'b1, 4'h0, 7'd5, 21'h0);
        e = exp_q.pop_front();
        checks++;
        if (douta !== 21'h1ABCDE || douta !== e) begin
            errors++;
            $display("FAIL basic_read: douta=%h required %h", douta, 21'h1ABCDE);
        end
    endtask

    task automatic test_lanes;
        logic [20:0] e;
        logic [3:0]  we_tab [3];
        logic [20:0] const_tab [3];
        we_tab[0] = 4'hF;      const_tab[0] = 21'h1FFFFF;
        we_tab[1] = 4'b0010;   const_tab[1] = 21'h1F00FF;
        we_tab[2] = 4'b1000;   const_tab[2] = 21'h1F00FF;
        for (int k = 0; k < 3; k++) begin
            step(1'b1, we_tab[k], 7'd9, (k == 0) ? 21'h1FFFFF : 21'h0);
            e = exp_q.pop_front();
            checks++;
            if (douta !== e) begin
                errors++;
                $display("FAIL lane_write_%0d: douta=%h required %h", k, douta, e);
            end
            step(1'b1, 4'h0, 7'd9, 21'h0);
            e = exp_q.pop_front();
            checks++;
            if (douta !== const_tab[k] || douta !== e) begin
                errors++;
                $display("FAIL lane_read_%0d: douta=%h required %h", k, douta, const_tab[k]);
            end
        end
        // Lane 2 alone on another entry, then lane 0 alone.
        step(1'b1, 4'b0100, 7'd10, 21'h1F0000);
        e = exp_q.pop_front();
        checks++;
        if (douta !== e) begin
            errors++;
            $display("FAIL lane2_only: douta=%h required %h", douta, e);
        end
        step(1'b1, 4'b0001, 7'd10, 21'h0000A5);
        e = exp_q.pop_front();
        checks++;
        if (douta !== e) begin
            errors++;
            $display("FAIL lane0_only: douta=%h required %h", douta, e);
        end
    endtask

    task automatic test_write_first;
        logic [20:0] e;
        step(1'b1, 4'h0, 7'd5, 21'h0);
        void'(exp_q.pop_front());
        step(1'b1, 4'hF, 7'd3, 21'h012345);
        e = exp_q.pop_front();
        checks++;
        if (douta !== 21'h012345 || douta !== e) begin
            errors++;
            $display("FAIL write_first: douta=%h required %h", douta, 21'h012345);
        end
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 4'hF, 7'd5, 21'h1FFFFF);
            e = exp_q.pop_front();
            checks++;
            if (douta !== e) begin
                errors++;
                $display("FAIL ena_hold_%0d: douta=%h required %h", k, douta, e);
            end
        end
        // The disabled write must not have reached entry 5.
        step(1'b1, 4'h0, 7'd5, 21'h0);
        e = exp_q.pop_front();
        checks++;
        if (douta !== e) begin
            errors++;
            $display("FAIL ena_no_write: douta=%h required %h", douta, e);
        end
    endtask

    task automatic test_back_to_back;
        logic [20:0] e;
        int bad;
        for (int i = 0; i < 128; i++) begin
            step(1'b1, 4'hF, 7'(i), 21'(i) | 21'h100000);
            void'(exp_q.pop_front());
        end
        bad = 0;
        for (int i = 0; i < 128; i++) begin
            step(1'b1, 4'h0, 7'(i), 21'h0);
            e = exp_q.pop_front();
            checks++;
            if (douta !== e) begin
                errors++;
                bad++;
                if (bad < 8) $display("FAIL b2b_read_%0d: douta=%h required %h", i, douta, e);
            end
        end
        // Read-after-write on consecutive cycles.
        step(1'b1, 4'hF, 7'd77, 21'h0ABCDE);
        void'(exp_q.pop_front());
        step(1'b1, 4'h0, 7'd77, 21'h0);
        e = exp_q.pop_front();
        checks++;
        if (douta !== e) begin
            errors++;
            $display("FAIL raw_next_cycle: douta=%h required %h", douta, e);
        end
    endtask

    task automatic test_reset_mid;
        logic [20:0] e;
        step(1'b1, 4'h0, 7'd127, 21'h0);
        void'(exp_q.pop_front());
        #2;
        rsta_n = 1'b0;
        #1;
        checks++;
        if (douta !== 21'h0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: douta=%h ready=%b required douta=0 ready=0", douta, ready);
        end
        @(posedge clka);
        #1;
        rsta_n = 1'b1;
        exp_last = 21'h0;
`ifndef ICACHE_TAG_CLEAR_EN
        @(posedge clka);
        #1;
        checks++;
        if (ready !== 1'b1 || douta !== 21'h0) begin
            errors++;
            $display("FAIL ready_after_reset: ready=%b douta=%h required ready=1 douta=0", ready, douta);
        end
        step(1'b1, 4'h0, 7'd50, 21'h0);
        e = exp_q.pop_front();
        checks++;
        if (douta !== e) begin
            errors++;
            $display("FAIL mem_retained: douta=%h required %h", douta, e);
        end
`else
        for (int k = 1; k <= 129; k++) begin
            ena   = 1'b1;
            wea   = 4'hF;
            addra = 7'(k);
            dina  = 21'h1FFFFF;
            @(posedge clka);
            #1;
            checks++;
            if (k < 129 && (ready !== 1'b0 || douta !== 21'h0)) begin
                errors++;
                $display("FAIL sweep_busy_%0d: ready=%b douta=%h required ready=0 douta=0", k, ready, douta);
            end else if (k == 129 && ready !== 1'b1) begin
                errors++;
                $display("FAIL sweep_done: ready=%b required 1", ready);
            end
        end
        ena = 1'b0;
        wea = 4'h0;
        for (int i = 0; i < 128; i++) model_mem[i] = 21'h0;
        step(1'b1, 4'h0, 7'd50, 21'h0);
        e = exp_q.pop_front();
        checks++;
        if (douta !== 21'h0 || douta !== e) begin
            errors++;
            $display("FAIL mid_reset_clear: douta=%h required 0", douta);
        end
`endif
    endtask

`ifdef ICACHE_TAG_CLEAR_EN
    task automatic test_clear_sweep;
        logic [20:0] e;
        step(1'b1, 4'hF, 7'd0, 21'h100001);
        void'(exp_q.pop_front());
        step(1'b1, 4'hF, 7'd127, 21'h100001);
        void'(exp_q.pop_front());
        rsta_n = 1'b0;
        #3;
        rsta_n = 1'b1;
        @(posedge clka);
        #1;
        for (int k = 2; k <= 129; k++) begin
            ena   = 1'b1;
            wea   = 4'hF;
            addra = (k % 2 == 0) ? 7'd0 : 7'd127;
            dina  = 21'h1FFFFF;
            checks++;
            if (ready !== 1'b0 || douta !== 21'h0) begin
                errors++;
                $display("FAIL clear_busy_%0d: ready=%b douta=%h required ready=0 douta=0", k, ready, douta);
            end
            @(posedge clka);
            #1;
        end
        ena = 1'b0;
        wea = 4'h0;
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL clear_ready: ready=%b required 1", ready);
        end
        for (int i = 0; i < 128; i++) model_mem[i] = 21'h0;
        exp_last = 21'h0;
        step(1'b1, 4'h0, 7'd0, 21'h0);
        e = exp_q.pop_front();
        checks++;
        if (douta !== 21'h0 || douta !== e) begin
            errors++;
            $display("FAIL clear_entry0: douta=%h required 0", douta);
        end
        step(1'b1, 4'h0, 7'd127, 21'h0);
        e = exp_q.pop_front();
        checks++;
        if (douta !== 21'h0 || douta !== e) begin
            errors++;
            $display("FAIL clear_entry127: douta=%h required 0", douta);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 128; i++) model_mem[i] = 21'h0;
        exp_last = 21'h0;
        test_reset();
        test_basic();
        test_lanes();
        test_write_first();
        test_back_to_back();
        test_reset_mid();
`ifdef ICACHE_TAG_CLEAR_EN
        test_clear_sweep();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: pending=%0d required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
